// File: rtl/vn_collector_pkg.sv
// Shared constants for the VN reduction-network datapath: word width,
// lane indices and drop-counter width.
package vn_collector_pkg;

    localparam int DATA_TYPE_DEFAULT = 32;

    localparam int LANE0 = 0;
    localparam int LANE1 = 1;

    localparam int DROP_CNT_W = 16;

endpackage : vn_collector_pkg

// File: rtl/vn_fifo_mem.sv
// DEPTH x DATA_TYPE register array, two write ports and one asynchronous read port.
// No reset: contents are only meaningful between the read and write pointers.
module vn_fifo_mem
    import vn_collector_pkg::*;
#(
    parameter int DATA_TYPE = DATA_TYPE_DEFAULT,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 4
) (
    input  logic                 clk,
    input  logic [PTR_W-1:0]     i_wr_addr_a,
    input  logic [DATA_TYPE-1:0] i_wr_data_a,
    input  logic                 i_wr_en_a,
    input  logic [PTR_W-1:0]     i_wr_addr_b,
    input  logic [DATA_TYPE-1:0] i_wr_data_b,
    input  logic                 i_wr_en_b,
    input  logic [PTR_W-1:0]     i_rd_addr,
    output logic [DATA_TYPE-1:0] o_rd_data
);

    logic [DATA_TYPE-1:0] r_mem [DEPTH];

    // The two write addresses are always consecutive slots, so they never collide.
    always_ff @(posedge clk) begin
        if (i_wr_en_a) begin
            r_mem[i_wr_addr_a] <= i_wr_data_a;
        end
        if (i_wr_en_b) begin
            r_mem[i_wr_addr_b] <= i_wr_data_b;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : vn_fifo_mem

// File: rtl/vn_collector.sv
// Collects up to two VN words per cycle from the root adder switch, compacts
// them into an in-order FIFO and drains one word per cycle; overflow is counted.
module vn_collector
    import vn_collector_pkg::*;
#(
    parameter int DATA_TYPE = DATA_TYPE_DEFAULT,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*DATA_TYPE-1:0] i_vn,
    input  logic [1:0]             i_vn_valid,
    output logic [DATA_TYPE-1:0]   o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [PTR_W:0]         o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_overflow,
    output logic [DROP_CNT_W-1:0]  o_drop_cnt
);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic [DATA_TYPE-1:0]  w_lane0;
    logic [DATA_TYPE-1:0]  w_lane1;
    logic [DATA_TYPE-1:0]  w_first;
    logic [DATA_TYPE-1:0]  w_rd_data;
    logic [1:0]            w_nv;
    logic [1:0]            w_nw;
    logic [1:0]            w_nd;
    logic [PTR_W:0]        w_free;
    logic [PTR_W:0]        w_count_next;
    logic                  w_pop;
    logic                  w_we_a;
    logic                  w_we_b;
    logic [PTR_W-1:0]      w_wr_addr_b;
    logic [DROP_CNT_W:0]   w_drop_sum;

    assign w_lane0 = i_vn[DATA_TYPE-1:0];
    assign w_lane1 = i_vn[2*DATA_TYPE-1:DATA_TYPE];

    assign w_nv   = {1'b0, i_vn_valid[LANE0]} + {1'b0, i_vn_valid[LANE1]};
    assign w_free = (PTR_W+1)'(DEPTH) - r_count;

    // Space comes only from the registered count; a same-cycle pop frees nothing.
    always_comb begin
        w_nw = w_nv;
        if ((PTR_W+1)'(w_nv) > w_free) begin
            w_nw = w_free[1:0];
        end
    end

    assign w_nd = w_nv - w_nw;

    // Compaction: slot wr_ptr gets the first valid lane, wr_ptr+1 only ever lane 1.
    assign w_first     = i_vn_valid[LANE0] ? w_lane0 : w_lane1;
    assign w_we_a      = !rst && (w_nw != 2'd0);
    assign w_we_b      = !rst && (w_nw == 2'd2);
    assign w_wr_addr_b = r_wr_ptr + PTR_W'(1);

    assign w_pop        = !r_empty && i_ready;
    assign w_count_next = r_count + (PTR_W+1)'(w_nw) - (PTR_W+1)'(w_pop);
    assign w_drop_sum   = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_nd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_nw);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == (PTR_W+1)'(DEPTH));
            r_empty <= (w_count_next == '0);
            if (w_nd != 2'd0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

    vn_fifo_mem #(
        .DATA_TYPE (DATA_TYPE),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk         (clk),
        .i_wr_addr_a (r_wr_ptr),
        .i_wr_data_a (w_first),
        .i_wr_en_a   (w_we_a),
        .i_wr_addr_b (w_wr_addr_b),
        .i_wr_data_b (w_lane1),
        .i_wr_en_b   (w_we_b),
        .i_rd_addr   (r_rd_ptr),
        .o_rd_data   (w_rd_data)
    );

    assign o_data     = r_empty ? '0 : w_rd_data;
    assign o_valid    = !r_empty;
    assign o_count    = r_count;
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;

endmodule : vn_collector

// File: tb/tb_vn_collector.sv
// Directed bench for vn_collector: reset, compaction, overflow, full pop+push,
// wrap-around streaming and mid-stream reset, with hand-computed expectations.
module tb_vn_collector;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic            clk;
    logic            rst;
    logic [2*DW-1:0] i_vn;
    logic [1:0]      i_vn_valid;
    logic [DW-1:0]   o_data;
    logic            o_valid;
    logic            i_ready;
    logic [PW:0]     o_count;
    logic            o_full;
    logic            o_empty;
    logic            o_overflow;
    logic [15:0]     o_drop_cnt;

    int n_checks;
    int n_errors;

    vn_collector #(
        .DATA_TYPE (DW),
        .DEPTH     (DEPTH),
        .PTR_W     (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_vn       (i_vn),
        .i_vn_valid (i_vn_valid),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [DW-1:0] l0, input logic [DW-1:0] l1);
        i_vn_valid = v;
        i_vn       = {l1, l0};
    endtask

    initial begin
        logic [DW-1:0] exp_w;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        i_ready = 1'b0;
        drive(2'b00, '0, '0);
        repeat (3) step();
        rst = 1'b0;

        chk("rst_valid",    o_valid,    1'b0);
        chk("rst_empty",    o_empty,    1'b1);
        chk("rst_full",     o_full,     1'b0);
        chk("rst_data",     o_data,     32'h0);
        chk("rst_count",    o_count,    5'd0);
        chk("rst_overflow", o_overflow, 1'b0);
        chk("rst_drop",     o_drop_cnt, 16'd0);

        // Single lane into an empty FIFO with i_ready high: no same-cycle pop.
        i_ready = 1'b1;
        drive(2'b01, 32'h3F800000, 32'hDEADBEEF);
        step();
        drive(2'b00, '0, '0);
        chk("single_valid", o_valid, 1'b1);
        chk("single_data",  o_data,  32'h3F800000);
        chk("single_count", o_count, 5'd1);
        step();
        chk("single_drain_count", o_count, 5'd0);
        chk("single_drain_empty", o_empty, 1'b1);
        i_ready = 1'b0;

        // Compaction order: {A,B} then lane-1-only C.
        drive(2'b11, 32'hAAAA0001, 32'hBBBB0002);
        step();
        drive(2'b10, 32'hDDDD0004, 32'hCCCC0003);
        step();
        drive(2'b00, '0, '0);
        chk("cmp_count", o_count, 5'd3);
        chk("cmp_a",     o_data,  32'hAAAA0001);
        step();
        chk("cmp_hold",  o_data,  32'hAAAA0001);
        i_ready = 1'b1;
        step();
        chk("cmp_b",     o_data,  32'hBBBB0002);
        step();
        chk("cmp_c",     o_data,  32'hCCCC0003);
        step();
        chk("cmp_empty", o_empty, 1'b1);
        chk("cmp_data0", o_data,  32'h0);
        i_ready = 1'b0;

        // Fill to 15 entries: words 100..114.
        for (int i = 0; i < 7; i++) begin
            drive(2'b11, 32'd100 + 32'(2*i), 32'd101 + 32'(2*i));
            step();
        end
        drive(2'b01, 32'd114, 32'hFFFF_FFFF);
        step();
        drive(2'b00, '0, '0);
        chk("fill15_count", o_count, 5'd15);
        chk("fill15_full",  o_full,  1'b0);
        chk("fill15_ovf",   o_overflow, 1'b0);

        // Partial overflow: X stored, Y dropped.
        drive(2'b11, 32'h0000_0A0A, 32'h0000_0B0B);
        step();
        drive(2'b00, '0, '0);
        chk("povf_count", o_count,    5'd16);
        chk("povf_full",  o_full,     1'b1);
        chk("povf_ovf",   o_overflow, 1'b1);
        chk("povf_drop",  o_drop_cnt, 16'd1);
        chk("povf_head",  o_data,     32'd100);

        // Full with pop and dual push: pop succeeds, both words dropped.
        i_ready = 1'b1;
        drive(2'b11, 32'h0000_0C0C, 32'h0000_0D0D);
        step();
        drive(2'b00, '0, '0);
        chk("fpp_count", o_count,    5'd15);
        chk("fpp_full",  o_full,     1'b0);
        chk("fpp_drop",  o_drop_cnt, 16'd3);

        // Drain: 101..114 then X.
        for (int k = 0; k < 15; k++) begin
            exp_w = (k < 14) ? 32'd101 + 32'(k) : 32'h0000_0A0A;
            chk($sformatf("drain_%0d", k), o_data, exp_w);
            step();
        end
        chk("drain_empty",  o_empty,    1'b1);
        chk("drain_ovf",    o_overflow, 1'b1);
        chk("drain_drop",   o_drop_cnt, 16'd3);
        i_ready = 1'b0;

        // Wrap-around streaming from a clean reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(2'b01, 32'h1000 + 32'(i), 32'hEEEE_EEEE);
            step();
            chk($sformatf("wrap_data_%0d", i),  o_data,  32'h1000 + 32'(i));
            chk($sformatf("wrap_count_%0d", i), o_count, 5'd1);
        end
        drive(2'b00, '0, '0);
        step();
        chk("wrap_end_count", o_count,    5'd0);
        chk("wrap_end_ovf",   o_overflow, 1'b0);
        chk("wrap_end_drop",  o_drop_cnt, 16'd0);
        i_ready = 1'b0;

        // Mid-stream reset: 7 entries held with overflow set.
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 32'h2000 + 32'(2*i), 32'h2001 + 32'(2*i));
            step();
        end
        drive(2'b01, 32'h2FFF, 32'h0);
        step();
        drive(2'b00, '0, '0);
        chk("mid_drop1", o_drop_cnt, 16'd1);
        i_ready = 1'b1;
        repeat (9) step();
        i_ready = 1'b0;
        chk("mid_count7", o_count,    5'd7);
        chk("mid_ovf",    o_overflow, 1'b1);
        chk("mid_head",   o_data,     32'h2009);

        rst = 1'b1;
        i_ready = 1'b1;
        drive(2'b11, 32'h3333, 32'h4444);
        step();
        chk("mrst_count", o_count,    5'd0);
        chk("mrst_valid", o_valid,    1'b0);
        chk("mrst_ovf",   o_overflow, 1'b0);
        chk("mrst_drop",  o_drop_cnt, 16'd0);
        chk("mrst_data",  o_data,     32'h0);
        chk("mrst_empty", o_empty,    1'b1);
        rst = 1'b0;
        i_ready = 1'b0;
        drive(2'b00, '0, '0);
        step();
        chk("post_count", o_count,    5'd0);
        chk("post_drop",  o_drop_cnt, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_vn_collector

// File: doc/vn_collector.md
# vn_collector

Sink for the two-lane VN output stream produced by an edge adder switch at the root of the reduction network. Each cycle it accepts zero, one or two valid VN words and compacts them, lane 0 first, into an in-order FIFO. It drains the FIFO one word per cycle over a valid/ready interface toward the output buffer or writeback path. Words that do not fit are dropped, and the block reports this through a sticky overflow flag and a saturating drop counter.

## Interface

Parameters:
- DATA_TYPE, 32, width of one VN word (FP32).
- DEPTH, 16, FIFO entries; power of two, at least 4.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_vn  input  2*DATA_TYPE  lane 0 = [DATA_TYPE-1:0], lane 1 = [2*DATA_TYPE-1:DATA_TYPE].
- i_vn_valid  input  2  bit k qualifies lane k.
- o_data  output  DATA_TYPE  head-of-FIFO word.
- o_valid  output  1  o_data is valid; equals !empty.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_count  output  PTR_W+1  occupied entries, 0..DEPTH.
- o_full  output  1  o_count == DEPTH.
- o_empty  output  1  o_count == 0.
- o_overflow  output  1  sticky; set when any valid lane is dropped.
- o_drop_cnt  output  16  dropped words, saturates at 16'hFFFF.

## Operation

- **Write (push):**
  - nv = popcount(i_vn_valid), range 0..2.
  - free = DEPTH - o_count, taken from the registered count at the start of the cycle. A pop in the same cycle does not add space; there is no bypass.
  - Valid lanes are ordered lane 0 then lane 1. Pattern 2'b10 writes only lane 1, into slot wr_ptr.
  - nw = min(nv, free). The first nw ordered words are written to slots wr_ptr and wr_ptr+1 (mod DEPTH). wr_ptr advances by nw.
- **Drop:**
  - nd = nv - nw.
  - If nd > 0, o_overflow is set and o_drop_cnt increases by nd, saturating.
  - Lane 1 is always the lane dropped when only one slot is free.
- **Read (pop):**
  - pop = o_valid && i_ready.
  - On pop, rd_ptr advances by 1 (mod DEPTH).
  - o_data = mem[rd_ptr] when o_valid, otherwise 0.
- **Count:** o_count_next = o_count + nw - pop. This never goes below 0 or above DEPTH.
- **Pointers:** PTR_W bits wide and wrap naturally. Full and empty are derived from o_count, not from pointer comparison.
- **Consumer rule:** o_data must stay stable while o_valid=1 and i_ready=0.
- **Reset:**
  - Pointers, o_count, o_overflow and o_drop_cnt go to 0.
  - Resulting outputs: o_valid=0, o_empty=1, o_full=0, o_data=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words. Inputs in the reset cycle are ignored and are not counted as drops.

## Timing

- Push latency: a word presented at edge N is visible on o_data/o_valid after edge N, i.e. in cycle N+1.
- Empty FIFO with a simultaneous push and i_ready=1: nothing pops that cycle, and the word appears the next cycle.
- Full FIFO with a simultaneous pop and push:
  - the pop succeeds;
  - the push is dropped in full;
  - o_count goes to DEPTH-1.
- o_count, o_full, o_empty, o_overflow and o_drop_cnt are all registered and update on the same edge as the push or pop.
- Throughput: up to 2 words in and 1 word out per cycle. Sustained dual-lane input therefore fills the FIFO at a net rate of 1 entry per cycle.
- No combinational path from i_vn or i_vn_valid to any output. i_ready affects only next-state logic.

## Structure

- Shared package holds:
  - the DATA_TYPE default;
  - the VN lane index constants (LANE0=0, LANE1=1);
  - the DROP_CNT_W=16 constant.
  - These are shared with the edge adder switch and the output buffer.
- Sub-module vn_fifo_mem: a DEPTH x DATA_TYPE register array with two write ports (addr/data/en) and one asynchronous read port. It has no reset.
- The top level owns:
  - lane compaction;
  - pointer, count and flag registers;
  - drop accounting.

## Test plan

- **Reset, then single-lane input.** Apply rst. Then drive i_vn_valid=2'b01 with lane0=32'h3F800000 for one cycle. Required: o_valid=1 next cycle, o_data=32'h3F800000, o_count=1.
- **Compaction order.** With i_ready=0:
  - cycle 1: 2'b11 with lane0=A, lane1=B;
  - cycle 2: 2'b10 with lane1=C.
  - Required: o_count=3. Raising i_ready drains A, B, C on consecutive cycles, then o_empty=1.
- **Partial overflow.** Fill to DEPTH-1 = 15 entries, then push 2'b11 with lanes X and Y. Required: X is stored, Y is dropped, o_full=1, o_overflow=1, o_drop_cnt=1.
- **Full with simultaneous pop and push.** With the FIFO at 16 entries, i_ready=1 and 2'b11 pushed. Required: head pops, both words dropped, o_count=15, o_drop_cnt increases by 2.
- **Wrap-around streaming.** 40 cycles of 2'b01 with i_ready=1 and incrementing data. Required: outputs appear in order with 1-cycle lag, o_count stays ≤1, no overflow.
- **Reset mid-stream.** Assert rst with 7 entries held and o_overflow=1. Required: next cycle o_count=0, o_valid=0, o_overflow=0, o_drop_cnt=0, o_data=0.
